// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use bubble insertion, EX operand forwarding,
// branch/jump flush and data-memory wait freeze for the 5-stage core.
// Control outputs are Mealy: they react to the current ID/EX/MEM inputs
// in the same cycle, and are masked to RUN values while rst_i is high.
module hazard_forward_ctrl #(
  parameter int REG_AW      = 5,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic                      id_redirect_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_memread_i,
  input  logic [REG_AW-1:0]         ex_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
  input  logic                      mem_valid_i,
  input  logic                      mem_regwrite_i,
  input  logic [REG_AW-1:0]         mem_rd_i,
  input  logic                      mem_req_i,
  input  logic                      mem_ready_i,
  input  logic                      wb_valid_i,
  input  logic                      wb_regwrite_i,
  input  logic [REG_AW-1:0]         wb_rd_i,
  output logic                      pc_write_o,
  output logic                      ifid_write_o,
  output logic                      ifid_flush_o,
  output logic                      idex_bubble_o,
  output logic                      pipe_hold_o,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o,
  output logic                      mem_timeout_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  // Wait counter is wide enough to reach MEM_TIMEOUT and still saturate above it.
  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 2) + 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [2:0]        LCNT_INIT = 3'(LOAD_LAT - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD_STALL,
    ST_MEM_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  state_t            r_resume;
  state_t            w_resume_nxt;
  state_t            w_eff_state;
  logic [2:0]        r_lcnt;
  logic [2:0]        w_lcnt_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_src_hit;
  logic              w_load_use;
  logic              w_mem_stall;
  logic              w_freeze;

  // Does any used ID source name the register the EX-stage load writes?
  always_comb begin
    w_src_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (id_src_used_i[k] && (id_src_i[k*REG_AW +: REG_AW] == ex_rd_i)) begin
        w_src_hit = 1'b1;
      end
    end
  end

  assign w_load_use  = ex_valid_i & ex_memread_i & (ex_rd_i != '0) & id_valid_i & w_src_hit;
  assign w_mem_stall = mem_req_i & ~mem_ready_i;

  // The ready cycle of a memory wait is not frozen; it behaves as the
  // resume state so a pending load-use or bubble sequence continues there.
  assign w_freeze = (r_state == ST_MEM_WAIT) ? ~mem_ready_i : w_mem_stall;

  // Next-state and Mealy control outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_resume_nxt  = r_resume;
    w_lcnt_nxt    = r_lcnt;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_timeout;
    w_eff_state   = r_state;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;

    if (r_state == ST_MEM_WAIT) begin
      if ((MEM_TIMEOUT != 0) && (r_wait_cnt == TIMEOUT_V)) begin
        w_timeout_nxt = 1'b1;
      end
      if (mem_ready_i) begin
        w_eff_state = r_resume;
      end
    end

    if (rst_i) begin
      w_state_nxt = ST_RUN;
    end else if (w_freeze) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
      w_state_nxt  = ST_MEM_WAIT;
      if (r_state == ST_MEM_WAIT) begin
        if (r_wait_cnt != '1) begin
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end else begin
        w_wait_nxt   = WAIT_W'(1);
        w_resume_nxt = r_state;
      end
    end else begin
      case (w_eff_state)
        ST_LOAD_STALL: begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
          if (r_lcnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
            w_lcnt_nxt  = '0;
          end else begin
            w_state_nxt = ST_LOAD_STALL;
            w_lcnt_nxt  = r_lcnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          if (w_load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = ST_LOAD_STALL;
              w_lcnt_nxt  = LCNT_INIT;
            end
          end else begin
            ifid_flush_o = id_redirect_i;
          end
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_resume   <= ST_RUN;
      r_lcnt     <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_resume   <= w_resume_nxt;
      r_lcnt     <= w_lcnt_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Sticky timeout flag and saturating stall-cycle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_timeout <= w_timeout_nxt;
      if (!pc_write_o && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Per-slot forward select, MEM result preferred over WB.
  always_comb begin
    fwd_sel_o = '0;
    if (!rst_i) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (mem_valid_i && mem_regwrite_i && (mem_rd_i != '0) &&
            (mem_rd_i == ex_src_i[k*REG_AW +: REG_AW])) begin
          fwd_sel_o[2*k +: 2] = 2'b10;
        end else if (wb_valid_i && wb_regwrite_i && (wb_rd_i != '0) &&
                     (wb_rd_i == ex_src_i[k*REG_AW +: REG_AW])) begin
          fwd_sel_o[2*k +: 2] = 2'b01;
        end
      end
    end
  end

  assign mem_timeout_o = r_timeout;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: three instances with different LOAD_LAT,
// MEM_TIMEOUT and CNT_W share one stimulus set; each scenario checks one.
module tb_hazard_forward_ctrl;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int LL [3] = '{1, 3, 2};
  localparam int TO [3] = '{0, 3, 0};
  localparam int CW [3] = '{16, 16, 3};
  localparam logic [4:0] C_RUN = 5'b11000;  // {pc_write, ifid_write, flush, bubble, hold}
  localparam logic [4:0] C_FL  = 5'b11100;
  localparam logic [4:0] C_BUB = 5'b00010;
  localparam logic [4:0] C_FRZ = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic id_valid, id_redirect, ex_valid, ex_memread;
  logic mem_valid, mem_regwrite, mem_req, mem_ready, wb_valid, wb_regwrite;
  logic [NS*AW-1:0] id_src, ex_src;
  logic [NS-1:0] id_src_used;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;

  logic pc_write [3];
  logic ifid_write [3];
  logic ifid_flush [3];
  logic idex_bubble [3];
  logic pipe_hold [3];
  logic [2*NS-1:0] fwd [3];
  logic tmo [3];
  logic [15:0] cnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [CW[g]-1:0] w_cnt;
    hazard_forward_ctrl #(
      .REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(LL[g]), .MEM_TIMEOUT(TO[g]), .CNT_W(CW[g])
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .id_valid_i(id_valid), .id_src_i(id_src), .id_src_used_i(id_src_used),
      .id_redirect_i(id_redirect),
      .ex_valid_i(ex_valid), .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .ex_src_i(ex_src),
      .mem_valid_i(mem_valid), .mem_regwrite_i(mem_regwrite), .mem_rd_i(mem_rd),
      .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .wb_valid_i(wb_valid), .wb_regwrite_i(wb_regwrite), .wb_rd_i(wb_rd),
      .pc_write_o(pc_write[g]), .ifid_write_o(ifid_write[g]), .ifid_flush_o(ifid_flush[g]),
      .idex_bubble_o(idex_bubble[g]), .pipe_hold_o(pipe_hold[g]), .fwd_sel_o(fwd[g]),
      .mem_timeout_o(tmo[g]), .stall_cnt_o(w_cnt)
    );
    assign cnt[g] = 16'(w_cnt);
  end

  typedef struct {
    int          sel;
    logic [4:0]  ctl;
    logic [3:0]  fwd;
    logic        to;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_cnt;
  logic [4:0]  ectl;
  logic [3:0]  efwd;
  logic        eto;

  function automatic logic [4:0] ctl_of(input int s);
    return {pc_write[s], ifid_write[s], ifid_flush[s], idex_bubble[s], pipe_hold[s]};
  endfunction

  function automatic logic [15:0] cap_of(input int s);
    return (s == 2) ? 16'd7 : 16'hFFFF;
  endfunction

  task automatic clear_inputs();
    id_valid = 0; id_redirect = 0; ex_valid = 0; ex_memread = 0;
    mem_valid = 0; mem_regwrite = 0; mem_req = 0; mem_ready = 0;
    wb_valid = 0; wb_regwrite = 0;
    id_src = '0; ex_src = '0; id_src_used = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
  endtask

  task automatic set_load_use();
    ex_valid = 1; ex_memread = 1; ex_rd = 5'd8;
    id_valid = 1; id_src = {5'd0, 5'd8}; id_src_used = 2'b01;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    m_cnt = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    set_load_use();
    mem_req = 1; id_redirect = 1;
    mem_valid = 1; mem_regwrite = 1; mem_rd = 5'd5; ex_src = {5'd5, 5'd5};
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 3; s++) sb.push_back('{s, C_RUN, 4'b0000, 1'b0, 16'd0});
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        e = sb.pop_front();
        checks++;
        if ({ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel]} !== {e.ctl, e.fwd, e.to, e.cnt}) begin
          errors++;
          $display("FAIL reset dut%0d c%0d: got ctl=%b fwd=%b to=%b cnt=%0d want ctl=%b fwd=%b to=%b cnt=%0d",
                   e.sel, c, ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel], e.ctl, e.fwd, e.to, e.cnt);
        end
      end
      @(posedge clk); #1;
    end
    rst = 0;
  endtask

  // LOAD_LAT=1 instance: single bubble, used-flag and x0 masking, back-to-back loads.
  task automatic test_load_lat1();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      clear_inputs(); ectl = C_RUN; efwd = '0; eto = 0;
      case (c)
        0: begin set_load_use(); ectl = C_BUB; end
        2: begin set_load_use(); ex_rd = 5'd0; id_src = '0; end
        3: begin set_load_use(); id_src = {5'd8, 5'd1}; end
        4: begin set_load_use(); id_src = {5'd8, 5'd1}; id_src_used = 2'b10; ectl = C_BUB; end
        5: begin set_load_use(); ex_rd = 5'd9; id_src = {5'd9, 5'd1}; id_src_used = 2'b11; ectl = C_BUB; end
        6: begin id_redirect = 1; ectl = C_FL; end
        default: ;
      endcase
      sb.push_back('{0, ectl, efwd, eto, m_cnt});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel]} !== {e.ctl, e.fwd, e.to, e.cnt}) begin
        errors++;
        $display("FAIL load_lat1 c%0d: got ctl=%b fwd=%b to=%b cnt=%0d want ctl=%b fwd=%b to=%b cnt=%0d",
                 c, ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel], e.ctl, e.fwd, e.to, e.cnt);
      end
      if (!e.ctl[4] && m_cnt != cap_of(e.sel)) m_cnt = m_cnt + 16'd1;
      @(posedge clk); #1;
    end
  endtask

  // LOAD_LAT=3 instance: three bubbles, redirect ignored while bubbling.
  task automatic test_load_lat3();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      clear_inputs(); ectl = C_RUN; efwd = '0; eto = 0;
      case (c)
        0: begin set_load_use(); ectl = C_BUB; end
        1: ectl = C_BUB;
        2: begin id_redirect = 1; ectl = C_BUB; end
        3: begin id_redirect = 1; ectl = C_FL; end
        default: ;
      endcase
      sb.push_back('{1, ectl, efwd, eto, m_cnt});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel]} !== {e.ctl, e.fwd, e.to, e.cnt}) begin
        errors++;
        $display("FAIL load_lat3 c%0d: got ctl=%b fwd=%b to=%b cnt=%0d want ctl=%b fwd=%b to=%b cnt=%0d",
                 c, ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel], e.ctl, e.fwd, e.to, e.cnt);
      end
      if (!e.ctl[4] && m_cnt != cap_of(e.sel)) m_cnt = m_cnt + 16'd1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      clear_inputs(); ectl = C_RUN; eto = 0;
      mem_valid = 1; mem_regwrite = 1; wb_valid = 1; wb_regwrite = 1;
      mem_rd = 5'd5; wb_rd = 5'd5; ex_src = {5'd5, 5'd3};
      case (c)
        0: efwd = 4'b1000;
        1: begin mem_rd = 5'd0; efwd = 4'b0100; end
        2: begin mem_rd = 5'd0; wb_rd = 5'd0; ex_src = {5'd0, 5'd3}; efwd = 4'b0000; end
        3: begin mem_rd = 5'd3; efwd = 4'b0110; end
        4: begin mem_regwrite = 0; efwd = 4'b0100; end
        5: begin mem_valid = 0; wb_valid = 0; efwd = 4'b0000; end
        default: begin mem_rd = 5'd3; wb_regwrite = 0; efwd = 4'b0010; end
      endcase
      sb.push_back('{0, ectl, efwd, eto, m_cnt});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel]} !== {e.ctl, e.fwd, e.to, e.cnt}) begin
        errors++;
        $display("FAIL forwarding c%0d: got ctl=%b fwd=%b to=%b cnt=%0d want ctl=%b fwd=%b to=%b cnt=%0d",
                 c, ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel], e.ctl, e.fwd, e.to, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  // Four-cycle memory wait with a pending redirect, then a zero-wait access.
  task automatic test_mem_wait();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      clear_inputs(); ectl = C_RUN; efwd = '0; eto = 0;
      if (c < 4) begin mem_req = 1; id_redirect = 1; ectl = C_FRZ; end
      else if (c == 4) begin mem_req = 1; mem_ready = 1; id_redirect = 1; ectl = C_FL; end
      else if (c == 6) begin mem_req = 1; mem_ready = 1; end
      sb.push_back('{0, ectl, efwd, eto, m_cnt});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel]} !== {e.ctl, e.fwd, e.to, e.cnt}) begin
        errors++;
        $display("FAIL mem_wait c%0d: got ctl=%b fwd=%b to=%b cnt=%0d want ctl=%b fwd=%b to=%b cnt=%0d",
                 c, ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel], e.ctl, e.fwd, e.to, e.cnt);
      end
      if (!e.ctl[4] && m_cnt != cap_of(e.sel)) m_cnt = m_cnt + 16'd1;
      @(posedge clk); #1;
    end
  endtask

  // MEM_TIMEOUT=3: flag after three MEM_WAIT cycles, sticky, cleared by reset mid-wait.
  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      clear_inputs(); ectl = C_RUN; efwd = '0;
      eto = (c >= 4) && (c < 11);
      if (c < 6 || c == 8 || c == 9 || c == 10) begin mem_req = 1; ectl = C_FRZ; end
      else if (c == 6) begin mem_req = 1; mem_ready = 1; end
      if (c == 10) rst = 1;
      sb.push_back('{1, ectl, efwd, eto, m_cnt});
      @(negedge clk);
      e = sb.pop_front();
      if (c != 10) begin
        checks++;
        if ({ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel]} !== {e.ctl, e.fwd, e.to, e.cnt}) begin
          errors++;
          $display("FAIL timeout c%0d: got ctl=%b fwd=%b to=%b cnt=%0d want ctl=%b fwd=%b to=%b cnt=%0d",
                   c, ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel], e.ctl, e.fwd, e.to, e.cnt);
        end
        if (!e.ctl[4] && m_cnt != cap_of(e.sel)) m_cnt = m_cnt + 16'd1;
      end else begin
        m_cnt = '0;
      end
      @(posedge clk); #1;
      rst = 0;
    end
  endtask

  // LOAD_LAT=3 bubble sequence interrupted by a memory wait keeps its remaining count.
  task automatic test_load_stall_mem();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clear_inputs(); ectl = C_BUB; efwd = '0; eto = 0;
      case (c)
        0: set_load_use();
        1, 2: begin mem_req = 1; ectl = C_FRZ; end
        3: begin mem_req = 1; mem_ready = 1; end
        4: ;
        default: ectl = C_RUN;
      endcase
      sb.push_back('{1, ectl, efwd, eto, m_cnt});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel]} !== {e.ctl, e.fwd, e.to, e.cnt}) begin
        errors++;
        $display("FAIL load_stall_mem c%0d: got ctl=%b fwd=%b to=%b cnt=%0d want ctl=%b fwd=%b to=%b cnt=%0d",
                 c, ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel], e.ctl, e.fwd, e.to, e.cnt);
      end
      if (!e.ctl[4] && m_cnt != cap_of(e.sel)) m_cnt = m_cnt + 16'd1;
      @(posedge clk); #1;
    end
  endtask

  // LOAD_LAT=2: load-use and mem stall together freeze first, then two bubbles
  // (ready cycle re-evaluates load-use); then a long wait saturates the 3-bit counter.
  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 17; c++) begin
      clear_inputs(); ectl = C_RUN; efwd = '0; eto = 0;
      case (c)
        0, 1: begin set_load_use(); mem_req = 1; ectl = C_FRZ; end
        2: begin set_load_use(); mem_req = 1; mem_ready = 1; ectl = C_BUB; end
        3: ectl = C_BUB;
        4: ;
        15: begin mem_req = 1; mem_ready = 1; end
        16: ;
        default: begin mem_req = 1; ectl = C_FRZ; end
      endcase
      sb.push_back('{2, ectl, efwd, eto, m_cnt});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel]} !== {e.ctl, e.fwd, e.to, e.cnt}) begin
        errors++;
        $display("FAIL back_to_back c%0d: got ctl=%b fwd=%b to=%b cnt=%0d want ctl=%b fwd=%b to=%b cnt=%0d",
                 c, ctl_of(e.sel), fwd[e.sel], tmo[e.sel], cnt[e.sel], e.ctl, e.fwd, e.to, e.cnt);
      end
      if (!e.ctl[4] && m_cnt != cap_of(e.sel)) m_cnt = m_cnt + 16'd1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    m_cnt = '0;
    test_reset();
    test_load_lat1();
    test_load_lat3();
    test_forwarding();
    test_mem_wait();
    test_timeout();
    test_load_stall_mem();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
